dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter_pkg.sv | 28 ++
 rtl/dmem_port_arbiter_rr.sv | 25 ++
 rtl/dmem_port_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// load/store size encodings and requester IDs.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] LT_NONE = 3'b000;
  localparam logic [2:0] LT_LBU  = 3'b001;
  localparam logic [2:0] LT_LB   = 3'b010;
  localparam logic [2:0] LT_LHU  = 3'b011;
  localparam logic [2:0] LT_LH   = 3'b100;
  localparam logic [2:0] LT_LWU  = 3'b101;
  localparam logic [2:0] LT_LW   = 3'b110;
  localparam logic [2:0] LT_LD   = 3'b111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr.sv
// Two-input round-robin grant: on a tie the requester that did not win last
// time is picked; a lone request always wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id,
  output logic       any_valid
);

  always_comb begin
    grant_id  = 1'b0;
    grant     = 2'b00;
    any_valid = |valid;
    if (valid == 2'b11) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid[1];
    end
    if (any_valid) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the core LSU (m0) and DMA/debug (m1) onto one data-memory port
// with a fixed IDLE -> ACCESS -> RESP sequence per request.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  input  logic [2:0]        m0_load_type,
  input  logic [1:0]        m0_store_type,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic [2:0]        m1_load_type,
  input  logic [1:0]        m1_store_type,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_enable,
  output logic [2:0]        mem_load_type,
  output logic [1:0]        mem_store_type,
  input  logic [DATA_W-1:0] mem_read_data,
  output arb_state_e        fsm_state
);

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; the requester must hold valid and its fields
  // until then, and may change them freely afterwards.
  arb_state_e        state, state_nxt;
  logic              last_grant;
  logic [1:0]        grant;
  logic              grant_id;
  logic              any_valid;
  logic              accept;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [2:0]        lt_q;
  logic [1:0]        st_q;
  logic              owner_q;
  logic [DATA_W-1:0] rdata_q;

  rr_arbiter2 u_rr (
    .valid      ({m1_req_valid, m0_req_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id),
    .any_valid  (any_valid)
  );

  // Ready is also held low while reset is asserted.
  assign m0_req_ready = rst_n && (state == IDLE) && grant[0];
  assign m1_req_ready = rst_n && (state == IDLE) && grant[1];
  assign accept       = (state == IDLE) && any_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_DMA;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lt_q       <= LT_NONE;
      st_q       <= SZ_B;
      owner_q    <= REQ_LSU;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_id;
        owner_q    <= grant_id;
        addr_q     <= grant_id ? m1_addr       : m0_addr;
        wdata_q    <= grant_id ? m1_wdata      : m0_wdata;
        we_q       <= grant_id ? m1_we         : m0_we;
        lt_q       <= grant_id ? m1_load_type  : m0_load_type;
        st_q       <= grant_id ? m1_store_type : m0_store_type;
      end
      // Stores return zero data so the response path needs no extra gating.
      if (state == ACCESS) begin
        rdata_q <= we_q ? '0 : mem_read_data;
      end
    end
  end

  assign mem_address      = addr_q;
  assign mem_data         = wdata_q;
  assign mem_store_type   = st_q;
  assign mem_write_enable = (state == ACCESS) && we_q;
  assign mem_load_type    = ((state == ACCESS) && !we_q) ? lt_q : LT_NONE;

  assign m0_rsp_valid = (state == RESP) && (owner_q == REQ_LSU);
  assign m1_rsp_valid = (state == RESP) && (owner_q == REQ_DMA);
  assign m0_rdata     = (owner_q == REQ_LSU) ? rdata_q : '0;
  assign m1_rdata     = (owner_q == REQ_DMA) ? rdata_q : '0;
  assign fsm_state    = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: byte memory model, reference
// memory for expected load data, per-port expected-response queues.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic              m0_req_ready, m1_req_ready;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_we = 1'b0, m1_we = 1'b0;
  logic [2:0]        m0_load_type = '0, m1_load_type = '0;
  logic [1:0]        m0_store_type = '0, m1_store_type = '0;
  logic              m0_rsp_valid, m1_rsp_valid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_write_enable;
  logic [2:0]        mem_load_type;
  logic [1:0]        mem_store_type;
  logic [DATA_W-1:0] mem_read_data = '0;
  arb_state_e        fsm_state;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_load_type(m0_load_type),
    .m0_store_type(m0_store_type), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_load_type(m1_load_type),
    .m1_store_type(m1_store_type), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write_enable(mem_write_enable),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .mem_read_data(mem_read_data), .fsm_state(fsm_state)
  );

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [63:0] exp_q0[$], exp_q1[$];
  int          lat_q0[$], lat_q1[$];
  int          grant_log[$], grant_cyc[$];
  int          n_vec = 0, n_bad = 0, cyc = 0, wr_count = 0, n_rsp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] lt);
    case (lt)
      LT_LBU:  return {56'd0, raw[7:0]};
      LT_LB:   return {{56{raw[7]}}, raw[7:0]};
      LT_LHU:  return {48'd0, raw[15:0]};
      LT_LH:   return {{48{raw[15]}}, raw[15:0]};
      LT_LWU:  return {32'd0, raw[31:0]};
      LT_LW:   return {{32{raw[31]}}, raw[31:0]};
      LT_LD:   return raw;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [11:0] a, input logic [2:0] lt);
    logic [63:0] raw;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = ref_mem[a + 12'(i)];
    return extend(raw, lt);
  endfunction

  // One clock: memory model and response scoreboard at the falling edge,
  // then drop any request that was accepted on the following rising edge.
  task automatic cycle();
    logic        a0, a1;
    logic [11:0] ma;
    logic [63:0] raw;
    @(negedge clk);
    cyc++;
    ma = mem_address[11:0];
    if (mem_write_enable) begin
      wr_count++;
      for (int i = 0; i < (1 << mem_store_type); i++) mem[ma + 12'(i)] = mem_data[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[ma + 12'(i)];
    mem_read_data = extend(raw, mem_load_type);
    a0 = rst_n && m0_req_valid && m0_req_ready;
    a1 = rst_n && m1_req_valid && m1_req_ready;
    if (a0) begin lat_q0.push_back(cyc + 2); grant_log.push_back(0); grant_cyc.push_back(cyc); end
    if (a1) begin lat_q1.push_back(cyc + 2); grant_log.push_back(1); grant_cyc.push_back(cyc); end
    if (m0_rsp_valid || m1_rsp_valid) n_rsp++;
    if (m0_rsp_valid) begin
      check("m0_rsp_expected", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        check("m0_rdata", m0_rdata, exp_q0.pop_front());
        check("m0_latency", 64'(cyc), 64'(lat_q0.pop_front()));
        check("m1_rsp_quiet", 64'(m1_rsp_valid), 64'd0);
        check("m1_rdata_gated", m1_rdata, 64'd0);
      end
    end
    if (m1_rsp_valid) begin
      check("m1_rsp_expected", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) begin
        check("m1_rdata", m1_rdata, exp_q1.pop_front());
        check("m1_latency", 64'(cyc), 64'(lat_q1.pop_front()));
        check("m0_rsp_quiet", 64'(m0_rsp_valid), 64'd0);
        check("m0_rdata_gated", m0_rdata, 64'd0);
      end
    end
    @(posedge clk);
    #1;
    if (a0) m0_req_valid = 1'b0;
    if (a1) m1_req_valid = 1'b0;
  endtask

  task automatic issue(input int p, input logic we, input logic [11:0] a, input logic [63:0] wdata,
                       input logic [2:0] lt, input logic [1:0] st, input logic [63:0] exp);
    if (we) for (int i = 0; i < (1 << st); i++) ref_mem[a + 12'(i)] = wdata[8*i +: 8];
    if (p == 0) begin
      m0_addr = 64'(a); m0_wdata = wdata; m0_we = we; m0_load_type = lt; m0_store_type = st;
      m0_req_valid = 1'b1; exp_q0.push_back(exp);
    end else begin
      m1_addr = 64'(a); m1_wdata = wdata; m1_we = we; m1_load_type = lt; m1_store_type = st;
      m1_req_valid = 1'b1; exp_q1.push_back(exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m0_req_valid || m1_req_valid || exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_pending", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    cycle();
    cycle();
    exp_q0.delete(); exp_q1.delete(); lat_q0.delete(); lat_q1.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] saved;
    int         wr0, rsp0;
    for (int i = 0; i < 4096; i++) begin
      saved = 8'($urandom_range(0, 255));
      mem[i] = saved;
      ref_mem[i] = saved;
    end
    for (int i = 0; i < 8; i++) begin
      saved = 8'(8'h88 - 8'(i) * 8'h11);
      mem[12'h100 + 12'(i)] = saved;
      ref_mem[12'h100 + 12'(i)] = saved;
    end
    mem[12'h008] = 8'h80;
    ref_mem[12'h008] = 8'h80;

    rst_n = 1'b0;
    cycle();
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    check("rst_m0_ready", 64'(m0_req_ready), 64'd0);
    check("rst_m1_ready", 64'(m1_req_ready), 64'd0);
    check("rst_m0_rsp", 64'(m0_rsp_valid), 64'd0);
    check("rst_m1_rsp", 64'(m1_rsp_valid), 64'd0);
    check("rst_mem_we", 64'(mem_write_enable), 64'd0);
    check("rst_mem_lt", 64'(mem_load_type), 64'd0);
    check("rst_mem_addr", mem_address, 64'd0);
    check("rst_m0_rdata", m0_rdata, 64'd0);
    do_reset();

    // m0 doubleword load
    issue(0, 1'b0, 12'h100, 64'd0, LT_LD, SZ_D, 64'h1122334455667788);
    drain(20);

    // m1 word store then m0 sign-extending word load of the same address
    wr0 = wr_count;
    issue(1, 1'b1, 12'h040, 64'h00000000DEADBEEF, LT_NONE, SZ_W, 64'd0);
    drain(20);
    check("store_one_write", 64'(wr_count - wr0), 64'd1);
    wr0 = wr_count;
    issue(0, 1'b0, 12'h040, 64'd0, LT_LW, SZ_D, 64'hFFFFFFFFDEADBEEF);
    drain(20);
    check("load_no_write", 64'(wr_count - wr0), 64'd0);

    // byte loads, signed and unsigned
    issue(0, 1'b0, 12'h008, 64'd0, LT_LB, SZ_D, 64'hFFFFFFFFFFFFFF80);
    drain(20);
    issue(0, 1'b0, 12'h008, 64'd0, LT_LBU, SZ_D, 64'h0000000000000080);
    drain(20);

    // both ports requesting continuously after reset: 0,1,0,1 every 3 cycles
    do_reset();
    grant_log.delete(); grant_cyc.delete();
    for (int k = 0; k < 30 && grant_log.size() < 4; k++) begin
      if (!m0_req_valid) issue(0, 1'b0, 12'h100, 64'd0, LT_LD, SZ_D, 64'h1122334455667788);
      if (!m1_req_valid) issue(1, 1'b0, 12'h100, 64'd0, LT_LWU, SZ_D, 64'h0000000055667788);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), 64'((grant_log.size() > i) ? grant_log[i] : 9), 64'(i % 2));
      if (i > 0) check($sformatf("rr_spacing%0d", i),
                       64'((grant_cyc.size() > i) ? grant_cyc[i] - grant_cyc[i-1] : 0), 64'd3);
    end
    drain(40);

    // random traffic, disjoint address windows per port
    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? !m0_req_valid : !m1_req_valid) && $urandom_range(0, 1) == 1) begin
          logic        we;
          logic [11:0] a;
          logic [2:0]  lt;
          logic [1:0]  st;
          logic [63:0] wd;
          we = 1'($urandom_range(0, 1));
          a  = 12'((p == 0) ? 12'h800 : 12'hC00) + 12'($urandom_range(0, 127) * 8);
          wd = {$urandom, $urandom};
          lt = we ? LT_NONE : 3'($urandom_range(1, 7));
          st = 2'($urandom_range(0, 3));
          issue(p, we, a, wd, lt, st, we ? 64'd0 : ref_load(a, lt));
        end
      end
      cycle();
    end
    drain(60);

    // reset during the ACCESS cycle of a store
    m0_addr = 64'h200; m0_wdata = 64'h0123456789ABCDEF; m0_we = 1'b1;
    m0_load_type = LT_NONE; m0_store_type = SZ_D; m0_req_valid = 1'b1;
    for (int k = 0; k < 10 && m0_req_valid; k++) cycle();
    check("abort_in_access", 64'(fsm_state), 64'(ACCESS));
    wr0 = wr_count;
    saved = mem[12'h200];
    rst_n = 1'b0;
    #1;
    check("abort_state_idle", 64'(fsm_state), 64'(IDLE));
    check("abort_mem_we", 64'(mem_write_enable), 64'd0);
    cycle();
    cycle();
    lat_q0.delete(); lat_q1.delete();
    rst_n = 1'b1;
    rsp0 = n_rsp;
    for (int k = 0; k < 4; k++) cycle();
    check("abort_no_write", 64'(wr_count - wr0), 64'd0);
    check("abort_mem_byte", 64'(mem[12'h200]), 64'(saved));
    check("abort_no_rsp", 64'(n_rsp - rsp0), 64'd0);
    grant_log.delete(); grant_cyc.delete();
    issue(0, 1'b0, 12'h100, 64'd0, LT_LD, SZ_D, 64'h1122334455667788);
    issue(1, 1'b0, 12'h100, 64'd0, LT_LHU, SZ_D, 64'h0000000000007788);
    drain(30);
    check("post_reset_tie_m0", 64'((grant_log.size() > 0) ? grant_log[0] : 9), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
